uart_cmd_bridge: RTL and testbench

- Host-side command engine that connects directly to the UART core's FIFO interface.
- Pops received bytes from the RX FIFO, parses a 2- or 3-byte command, and performs one access on a simple register bus.
- Pushes a response byte into the TX FIFO.
- Gives a PC terminal read/write access to on-chip control registers over the 19,200-baud link.

---
 rtl/uart_cmd_bridge_if.sv | 25 ++
 rtl/uart_cmd_bridge.sv | 124 ++++++++++++
 tb/tb_uart_cmd_bridge.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_bridge_if.sv
// UART FIFO and register-bus signals shared by the command bridge and its peers.
// master = bridge side; slave = FIFO/register-file side.
interface uart_cmd_bridge_if #(parameter int W = 8);
  logic         rx_empty;
  logic [W-1:0] r_data;
  logic         rd_uart;
  logic         tx_full;
  logic [W-1:0] w_data;
  logic         wr_uart;
  logic [7:0]   reg_addr;
  logic [W-1:0] reg_wdata;
  logic         reg_wr;
  logic         reg_rd;
  logic [W-1:0] reg_rdata;

  modport master (
    input  rx_empty, r_data, tx_full, reg_rdata,
    output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd
  );

  modport slave (
    output rx_empty, r_data, tx_full, reg_rdata,
    input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART command engine: parses 'W' addr data / 'R' addr from the RX FIFO,
// performs one register-bus access and pushes a one-byte response to TX.
module uart_cmd_bridge #(
  parameter int W       = 8,
  parameter int TIMEOUT = 200000,
  parameter int TW      = 18
) (
  input  logic               clk,
  input  logic               reset,
  uart_cmd_bridge_if.master  bus,
  output logic               busy,
  output logic               cmd_err
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_WAIT, SEND
  } state_t;

  localparam logic [W-1:0]  OP_WR   = W'(8'h57);
  localparam logic [W-1:0]  OP_RD   = W'(8'h52);
  localparam logic [W-1:0]  RSP_OK  = W'(8'h4B);
  localparam logic [W-1:0]  RSP_BAD = W'(8'h3F);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic          is_wr, is_wr_n;
  logic [7:0]    addr_q, addr_n;
  logic [W-1:0]  wdata_q, wdata_n;
  logic [W-1:0]  tx_q, tx_n;
  logic [TW-1:0] cnt, cnt_n;
  logic          pop, err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      is_wr   <= is_wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      tx_q    <= tx_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    is_wr_n = is_wr;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    tx_n    = tx_q;
    cnt_n   = cnt;
    pop     = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!bus.rx_empty) begin
          pop = 1'b1;
          if (bus.r_data == OP_WR) begin
            is_wr_n = 1'b1;
            state_n = GET_ADDR;
          end else if (bus.r_data == OP_RD) begin
            is_wr_n = 1'b0;
            state_n = GET_ADDR;
          end else begin
            tx_n    = RSP_BAD;
            err     = 1'b1;
            state_n = SEND;
          end
        end
      end
      GET_ADDR, GET_DATA: begin
        if (!bus.rx_empty) begin
          pop   = 1'b1;
          cnt_n = '0;
          if (state == GET_ADDR) begin
            addr_n  = bus.r_data[7:0];
            state_n = is_wr ? GET_DATA : REG_RD;
          end else begin
            wdata_n = bus.r_data;
            state_n = REG_WR;
          end
        end else if (cnt == TO_LAST) begin
          // abandoned command: no response byte, no bus access
          err     = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      REG_WR: begin
        tx_n    = RSP_OK;
        state_n = SEND;
      end
      REG_RD:  state_n = RD_WAIT;
      RD_WAIT: begin
        tx_n    = bus.reg_rdata;
        state_n = SEND;
      end
      SEND: if (!bus.tx_full) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reset forces the state to IDLE, where pop would follow rx_empty; gate
  // the Mealy strobes so nothing fires while reset is held.
  assign bus.rd_uart   = pop & ~reset;
  assign cmd_err       = err & ~reset;
  assign bus.wr_uart   = (state == SEND) && !bus.tx_full;
  assign bus.reg_wr    = (state == REG_WR);
  assign bus.reg_rd    = (state == REG_RD);
  assign bus.w_data    = tx_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: FIFO/register-file models around the DUT and a
// byte-stream protocol model that predicts responses and register writes.
module tb_uart_cmd_bridge;
  localparam int W  = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, cmd_err;

  uart_cmd_bridge_if #(.W(W)) bus();

  uart_cmd_bridge #(.W(W), .TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  int total = 0, bad = 0, cyc = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int n_pop, n_err, n_viol, pop_cyc, wr_cyc, rd_cyc, tx_cyc, err_cyc;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_tx[$];
  logic [15:0] exp_wr[$];
  int exp_err;
  logic pop_f = 1'b0, rd_f = 1'b0;
  logic [7:0] rd_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // bus observer, mid-cycle
  always @(negedge clk) begin
    pop_f = bus.rd_uart;
    rd_f  = bus.reg_rd;
    rd_a  = bus.reg_addr;
    if (bus.rd_uart) begin n_pop++; pop_cyc = cyc; if (bus.rx_empty) n_viol++; end
    if (bus.wr_uart) begin tx_log.push_back(bus.w_data); tx_cyc = cyc; if (bus.tx_full) n_viol++; end
    if (bus.reg_wr) begin
      wr_log.push_back({bus.reg_addr, bus.reg_wdata});
      mem[bus.reg_addr] = bus.reg_wdata;
      wr_cyc = cyc;
    end
    if (bus.reg_rd) begin rd_log.push_back(bus.reg_addr); rd_cyc = cyc; end
    if (bus.reg_rd && bus.reg_wr) n_viol++;
    if (cmd_err) begin n_err++; err_cyc = cyc; end
  end

  // FWFT RX FIFO and register file; read data only valid the cycle after reg_rd
  always @(posedge clk) begin
    #1;
    if (pop_f && rx_q.size() > 0) void'(rx_q.pop_front());
    bus.reg_rdata = rd_f ? mem[rd_a] : 8'($urandom);
    bus.rx_empty  = (rx_q.size() == 0);
    bus.r_data    = (rx_q.size() == 0) ? 8'($urandom) : rx_q[0];
  end

  task automatic clear_logs();
    tx_log.delete(); wr_log.delete(); rd_log.delete();
    exp_tx.delete(); exp_wr.delete(); exp_err = 0;
    n_pop = 0; n_err = 0; n_viol = 0;
  endtask

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) rx_q.push_back(b[i]);
  endtask

  // Protocol model: whole commands in, expected responses/writes out.
  task automatic ref_run(input bq_t b);
    int i = 0;
    while (i < b.size()) begin
      if (b[i] == 8'h57 && i + 2 < b.size()) begin
        exp_wr.push_back({b[i+1], b[i+2]});
        ref_mem[b[i+1]] = b[i+2];
        exp_tx.push_back(8'h4B);
        i += 3;
      end else if (b[i] == 8'h52 && i + 1 < b.size()) begin
        exp_tx.push_back(ref_mem[b[i+1]]);
        i += 2;
      end else begin
        exp_tx.push_back(8'h3F);
        exp_err++;
        i += 1;
      end
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    int stable = 0;
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !busy && !bus.tx_full) stable++; else stable = 0;
      if (stable >= 3) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_expected(input string name);
    total++;
    if (tx_log.size() != exp_tx.size()) begin
      bad++; $display("FAIL %s tx_count: got %0d want %0d", name, tx_log.size(), exp_tx.size());
    end else foreach (exp_tx[i]) if (tx_log[i] !== exp_tx[i]) begin
      bad++; $display("FAIL %s tx[%0d]: got %02h want %02h", name, i, tx_log[i], exp_tx[i]); break;
    end
    total++;
    if (wr_log.size() != exp_wr.size()) begin
      bad++; $display("FAIL %s wr_count: got %0d want %0d", name, wr_log.size(), exp_wr.size());
    end else foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) begin
      bad++; $display("FAIL %s wr[%0d]: got %04h want %04h", name, i, wr_log[i], exp_wr[i]); break;
    end
    total++;
    if (n_err != exp_err) begin bad++; $display("FAIL %s cmd_err_count: got %0d want %0d", name, n_err, exp_err); end
    total++;
    if (n_viol != 0) begin bad++; $display("FAIL %s handshake_violations: got %0d want 0", name, n_viol); end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bus.rd_uart, bus.wr_uart, bus.reg_wr, bus.reg_rd, cmd_err, busy,
         bus.w_data, bus.reg_addr, bus.reg_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs w_data=%02h addr=%02h busy=%b", bus.w_data, bus.reg_addr, busy);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || n_pop != 0) begin bad++; $display("FAIL reset_idle: got busy=%b pops=%0d want 0/0", busy, n_pop); end
  endtask

  task automatic test_write();
    bit ok;
    bq_t b = '{8'h57, 8'h10, 8'hA5};
    clear_logs(); ref_run(b); push_bytes(b);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL write_done: got stuck want idle"); end
    check_expected("write");
    total++; if (n_pop != 3) begin bad++; $display("FAIL write_pops: got %0d want 3", n_pop); end
    total++; if (wr_cyc != pop_cyc + 1) begin bad++; $display("FAIL write_wr_latency: got %0d want %0d", wr_cyc - pop_cyc, 1); end
    total++; if (tx_cyc != wr_cyc + 1) begin bad++; $display("FAIL write_tx_latency: got %0d want %0d", tx_cyc - wr_cyc, 1); end
    total++; if (rd_log.size() != 0) begin bad++; $display("FAIL write_no_rd: got %0d want 0", rd_log.size()); end
  endtask

  task automatic test_read();
    bit ok;
    bq_t b = '{8'h52, 8'h22};
    mem[8'h22] = 8'h3C; ref_mem[8'h22] = 8'h3C;
    clear_logs(); ref_run(b); push_bytes(b);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL read_done: got stuck want idle"); end
    check_expected("read");
    total++;
    if (rd_log.size() != 1 || rd_log[0] !== 8'h22) begin
      bad++; $display("FAIL read_strobe: got count=%0d want 1 at addr 22", rd_log.size());
    end
    total++; if (rd_cyc != pop_cyc + 1) begin bad++; $display("FAIL read_rd_latency: got %0d want 1", rd_cyc - pop_cyc); end
    total++; if (tx_cyc != rd_cyc + 2) begin bad++; $display("FAIL read_tx_latency: got %0d want 2", tx_cyc - rd_cyc); end
  endtask

  task automatic test_bad_opcode();
    bit ok;
    bq_t b = '{8'h41};
    clear_logs(); ref_run(b); push_bytes(b);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL badop_done: got busy=%b want 0", busy); end
    check_expected("badop");
    total++; if (rd_log.size() != 0) begin bad++; $display("FAIL badop_no_rd: got %0d want 0", rd_log.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int drop_cyc;
    bq_t b = '{8'h57, 8'h44, 8'h99};
    clear_logs(); ref_run(b);
    @(posedge clk); #1 bus.tx_full = 1'b1;
    push_bytes(b);
    repeat (50) @(posedge clk);
    @(negedge clk);
    total++; if (tx_log.size() != 0 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_hold: got tx=%0d busy=%b want 0/1", tx_log.size(), busy);
    end
    @(posedge clk); #1 bus.tx_full = 1'b0; drop_cyc = cyc;
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done: got stuck want idle"); end
    check_expected("backpressure");
    total++; if (tx_cyc != drop_cyc) begin bad++; $display("FAIL bp_push_cycle: got %0d want %0d", tx_cyc, drop_cyc); end
  endtask

  task automatic test_timeout();
    bit ok;
    int addr_pop;
    bq_t b = '{8'h57, 8'h10};
    bq_t r = '{8'h52, 8'h10};
    clear_logs(); push_bytes(b);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (n_err > 0) begin ok = 1'b1; break; end
    end
    addr_pop = pop_cyc;
    total++; if (!ok) begin bad++; $display("FAIL timeout_err: got no cmd_err want pulse"); end
    total++; if (err_cyc != addr_pop + TO) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", err_cyc - addr_pop, TO); end
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || wr_log.size() != 0 || tx_log.size() != 0 || n_err != 1) begin
      bad++; $display("FAIL timeout_abort: got busy=%b wr=%0d tx=%0d err=%0d want 0/0/0/1", busy, wr_log.size(), tx_log.size(), n_err);
    end
    clear_logs(); ref_run(r); push_bytes(r);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_recover: got stuck want idle"); end
    check_expected("timeout_recover");
  endtask

  task automatic test_back_to_back();
    bit ok;
    bq_t b = '{8'h57, 8'h01, 8'h02, 8'h52, 8'h01};
    clear_logs(); ref_run(b); push_bytes(b);
    wait_idle(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done: got stuck want idle"); end
    check_expected("back_to_back");
  endtask

  task automatic test_random();
    bit ok;
    bq_t b;
    logic [7:0] op;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 4))
        0, 1: begin b.push_back(8'h57); b.push_back(8'($urandom_range(0, 15))); b.push_back(8'($urandom)); end
        2, 3: begin b.push_back(8'h52); b.push_back(8'($urandom_range(0, 15))); end
        default: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
          b.push_back(op);
        end
      endcase
    end
    clear_logs(); ref_run(b); push_bytes(b);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1 bus.tx_full = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1 bus.tx_full = 1'b0;
    wait_idle(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL random_done: got stuck want idle"); end
    check_expected("random");
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); push_bytes('{8'h57, 8'h33});
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (n_pop == 2) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_pops: got %0d want 2", n_pop); end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.rd_uart, bus.wr_uart, bus.reg_wr, bus.reg_rd, cmd_err, busy,
         bus.w_data, bus.reg_addr, bus.reg_wdata} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: got addr=%02h busy=%b want all 0", bus.reg_addr, busy);
    end
    @(posedge clk); #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (wr_log.size() != 0 || tx_log.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_discard: got wr=%0d tx=%0d busy=%b want 0/0/0", wr_log.size(), tx_log.size(), busy);
    end
  endtask

  initial begin
    bus.rx_empty = 1'b1; bus.r_data = '0; bus.tx_full = 1'b0; bus.reg_rdata = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    clear_logs();
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit want completion");
    $fatal(1, "watchdog");
  end
endmodule
